// File: rtl/servant_rr_arbiter.sv
// Round-robin arbiter sharing one classic-Wishbone slave among N masters.
// A grant is held until the slave acks, the master drops cyc or the watchdog fires.
module servant_rr_arbiter #(
    parameter int N       = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N*AW-1:0]   i_wb_m_adr,
    input  logic [N*DW-1:0]   i_wb_m_dat,
    input  logic [N*DW/8-1:0] i_wb_m_sel,
    input  logic [N-1:0]      i_wb_m_we,
    input  logic [N-1:0]      i_wb_m_cyc,
    output logic [DW-1:0]     o_wb_m_rdt,
    output logic [N-1:0]      o_wb_m_ack,
    output logic [N-1:0]      o_wb_m_err,
    output logic [AW-1:0]     o_wb_s_adr,
    output logic [DW-1:0]     o_wb_s_dat,
    output logic [DW/8-1:0]   o_wb_s_sel,
    output logic              o_wb_s_we,
    output logic              o_wb_s_cyc,
    input  logic [DW-1:0]     i_wb_s_rdt,
    input  logic              i_wb_s_ack,
    output logic [N-1:0]      o_grant
);

    localparam int SW    = DW / 8;
    localparam int LW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [LW-1:0]   g_idx;
    logic [LW-1:0]   pick_idx;
    logic            pick_found;
    logic            in_grant;
    logic            cyc_g;
    logic            ack_fire;
    logic            to_fire;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) g_idx = LW'(i);
        end
    end

    // Scan last+1, last+2, ... so the most recently served master comes last.
    always_comb begin
        int            j;
        logic [LW-1:0] jj;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            j = int'(last_q) + i;
            if (j >= N) j = j - N;
            jj = LW'(j);
            if (!pick_found && i_wb_m_cyc[jj]) begin
                pick_found = 1'b1;
                pick_idx   = jj;
            end
        end
    end

    assign in_grant = (state_q == S_GRANT);
    assign cyc_g    = i_wb_m_cyc[g_idx];
    assign ack_fire = in_grant && i_wb_s_ack;
    assign to_fire  = TO_EN && in_grant && cyc_g && !i_wb_s_ack && (cnt_q == CW'(TO_M1));

    assign o_wb_s_cyc = in_grant && cyc_g;
    assign o_wb_s_adr = i_wb_m_adr[g_idx*AW +: AW];
    assign o_wb_s_dat = i_wb_m_dat[g_idx*DW +: DW];
    assign o_wb_s_sel = i_wb_m_sel[g_idx*SW +: SW];
    assign o_wb_s_we  = i_wb_m_we[g_idx];
    assign o_wb_m_rdt = i_wb_s_rdt;
    assign o_wb_m_ack = ack_fire ? grant_q : '0;
    assign o_wb_m_err = to_fire ? grant_q : '0;
    assign o_grant    = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    grant_d = N'(1) << pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ack_fire || !cyc_g || to_fire) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = g_idx;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
